// File: rtl/supl_pkg.sv
// Shared types and sizing helpers for the iterative operand-mixing unit.
package supl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic EN_SHIFT = 1'b1;
  localparam logic EN_HALF  = 1'b0;

  // Width holding 0 + 1 + ... + (w-1), the worst-case zero-index sum.
  function automatic int sum_w(input int w);
    return $clog2(w * (w - 1) / 2 + 1);
  endfunction

  function automatic int zc_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/zero_slice_acc.sv
// Combinational zero finder over one K-bit slice of the operand:
// returns the sum of absolute indices of zero bits and their count.
module zero_slice_acc #(
  parameter int K     = 4,
  parameter int IDX_W = 5,
  parameter int SUM_W = 9,
  parameter int ZC_W  = 6
) (
  input  logic [K-1:0]     slice,
  input  logic [IDX_W-1:0] base,
  output logic [SUM_W-1:0] idx_sum,
  output logic [ZC_W-1:0]  zcnt
);

  always_comb begin
    idx_sum = '0;
    zcnt    = '0;
    for (int i = 0; i < K; i++) begin
      if (!slice[i]) begin
        idx_sum = idx_sum + SUM_W'(base) + SUM_W'(i);
        zcnt    = zcnt + ZC_W'(1);
      end
    end
  end

endmodule

// File: rtl/supl_iter.sv
// Iterative operand mixer: one-cycle XOR/NOR word, K-bit-per-cycle zero scan
// of a, results returned over a valid/ready handshake.
module supl_iter
  import supl_pkg::*;
#(
  parameter int  W     = 32,
  parameter int  K     = 4,
  parameter int  SHIFT = 4,
  localparam int SUM_W = sum_w(W),
  localparam int ZC_W  = zc_w(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             en,
  input  logic             sw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     xor0,
  output logic             o,
  output logic [SUM_W-1:0] sum,
  output logic [ZC_W-1:0]  zcnt
);

  localparam int IDX_W = $clog2(W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - K);

  state_t           state;
  logic [W-1:0]     a_r;
  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] acc_sum, s_sum;
  logic [ZC_W-1:0]  acc_zc, s_zc;
  logic [W-1:0]     mix;

  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    mix = '0;
    if (en == EN_SHIFT)
      mix = a ^ (b >> SHIFT);
    else
      mix = {a[W-1:W/2] ^ a[W/2-1:0], b[W-1:W/2] ^ b[W/2-1:0]};
  end

  zero_slice_acc #(
    .K    (K),
    .IDX_W(IDX_W),
    .SUM_W(SUM_W),
    .ZC_W (ZC_W)
  ) u_slice (
    .slice  (a_r[idx +: K]),
    .base   (idx),
    .idx_sum(s_sum),
    .zcnt   (s_zc)
  );

  // Accumulators run privately so sum/zcnt only move on SCAN->DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      idx       <= '0;
      acc_sum   <= '0;
      acc_zc    <= '0;
      xor0      <= '0;
      o         <= 1'b0;
      sum       <= '0;
      zcnt      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            idx     <= '0;
            acc_sum <= '0;
            acc_zc  <= '0;
            if (sw) begin
              xor0 <= mix;
              o    <= ~(a[0] | b[0]);
            end
            state <= SCAN;
          end
        end
        SCAN: begin
          acc_sum <= acc_sum + s_sum;
          acc_zc  <= acc_zc + s_zc;
          idx     <= idx + IDX_W'(K);
          if (idx == LAST_IDX) begin
            sum       <= acc_sum + s_sum;
            zcnt      <= acc_zc + s_zc;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_supl_iter.sv
// Directed self-checking bench for supl_iter (W=32, K=4, SHIFT=4).
module tb_supl_iter;

  localparam int W = 32;
  localparam int K = 4;
  localparam int SHIFT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          en = 1'b0;
  logic          sw = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  xor0;
  logic          o;
  logic [8:0]    sum;
  logic [5:0]    zcnt;

  int n_cmp = 0;
  int n_err = 0;

  supl_iter #(.W(W), .K(K), .SHIFT(SHIFT)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .en       (en),
    .sw       (sw),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .xor0     (xor0),
    .o        (o),
    .sum      (sum),
    .zcnt     (zcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand and hold it until the accepting edge has passed.
  task automatic offer(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic eni,
                       input logic swi);
    int t;
    a = ai; b = bi; en = eni; sw = swi; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("accept_timeout", 64'd1, 64'd0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                     input logic eni, input logic swi, input logic [W-1:0] ex,
                     input logic eo, input int es, input int ez);
    int n;
    offer(ai, bi, eni, swi);
    chk({tag, "_xor_acc"}, xor0, ex);
    chk({tag, "_o_acc"}, o, eo);
    chk({tag, "_busy"}, in_ready, 0);
    wait_done(n);
    chk({tag, "_lat"}, n, W / K);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_zcnt"}, zcnt, ez);
    chk({tag, "_xor"}, xor0, ex);
    chk({tag, "_o"}, o, eo);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, out_valid, 0);
    chk({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    int n;
    logic seen;

    // 1: reset
    tick(); tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_xor", xor0, 0);
    chk("rst_o", o, 0);
    chk("rst_sum", sum, 0);
    chk("rst_zcnt", zcnt, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    tick();

    // 2..4: shift mode, half mode, sw=0 holds
    run("t2", 32'h1234_5678, 32'hF000_0000, 1'b1, 1'b1, 32'h1D34_5678, 1'b1, 321, 19);
    run("t3", 32'hFFFF_0000, 32'h1234_1234, 1'b0, 1'b1, 32'hFFFF_0000, 1'b1, 120, 16);
    run("t4a", 32'h0000_0000, 32'hAAAA_5555, 1'b1, 1'b0, 32'hFFFF_0000, 1'b1, 496, 32);
    run("t4b", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 32'hFFFF_0000, 1'b1, 0, 1);
    run("t4c", 32'h7FFF_FFFF, 32'h1111_1111, 1'b1, 1'b0, 32'hFFFF_0000, 1'b1, 31, 1);

    // 5: backpressure while a new operand is already offered
    offer(32'h0000_FFFF, 32'h0, 1'b1, 1'b1);
    chk("t5_xor_acc", xor0, 32'h0000_FFFF);
    chk("t5_o_acc", o, 0);
    wait_done(n);
    chk("t5_lat", n, W / K);
    a = 32'h7FFF_FFFF; b = 32'h0000_00FF; en = 1'b1; sw = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_ov", out_valid, 1);
      chk("t5_hold_rdy", in_ready, 0);
      chk("t5_hold_xor", xor0, 32'h0000_FFFF);
      chk("t5_hold_sum", sum, 376);
      chk("t5_hold_zcnt", zcnt, 16);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_rel_ov", out_valid, 0);
    chk("t5_rel_rdy", in_ready, 1);
    chk("t5_rel_xor", xor0, 32'h0000_FFFF);
    tick();
    in_valid = 1'b0;
    chk("t5_acc2_rdy", in_ready, 0);
    chk("t5_acc2_xor", xor0, 32'h7FFF_FFF0);
    chk("t5_acc2_o", o, 0);
    wait_done(n);
    chk("t5_lat2", n, W / K);
    chk("t5_sum2", sum, 31);
    chk("t5_zcnt2", zcnt, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 6: reset mid-scan abandons the transaction
    offer(32'h0, 32'h0000_0010, 1'b1, 1'b1);
    chk("t6_xor_acc", xor0, 32'h1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_rdy", in_ready, 0);
    chk("t6_rst_ov", out_valid, 0);
    chk("t6_rst_xor", xor0, 0);
    chk("t6_rst_o", o, 0);
    chk("t6_rst_sum", sum, 0);
    chk("t6_rst_zcnt", zcnt, 0);
    rst = 1'b0;
    #1;
    chk("t6_post_rdy", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("t6_no_ov", seen, 0);
    run("t6b", 32'hFFFF_0000, 32'h1234_1234, 1'b0, 1'b1, 32'hFFFF_0000, 1'b1, 120, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/supl_iter.md
Name: supl_iter

Overview:
Parametrised, clocked successor of the combinational operand-mixing unit.
- Accepts operand pair a/b with mode bits en/sw over a valid/ready handshake.
- Computes the mixed XOR word and the NOR flag in one cycle.
- Scans a for zero bits K bits per cycle, producing the zero-index sum and the zero count.
- Returns results over a second valid/ready handshake; sits between the operand register file and the result collector.

Parameters:
W, 32, operand width; even, >=4.
K, 4, bits scanned per cycle; must divide W.
SHIFT, 4, logical right-shift applied to b in en=1 mode; 0..W-1.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand offer
in_ready  out  1  unit can accept operands
a  in  W  operand A
b  in  W  operand B
en  in  1  XOR mode select
sw  in  1  1 = update xor0/o for this transaction; 0 = hold previous values
out_valid  out  1  results available
out_ready  in  1  consumer takes results
xor0  out  W  mixed XOR word
o  out  1  NOR of a[0], b[0]
sum  out  SUM_W  sum of indices i where a[i]==0; SUM_W = clog2(W*(W-1)/2+1), 9 for W=32
zcnt  out  ZC_W  number of zero bits in a; ZC_W = clog2(W+1)

Behaviour:
- Reset: while rst=1 at an edge, state <= IDLE, xor0/o/sum/zcnt/out_valid <= 0, scan index <= 0. in_ready is 0 while rst is high.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, capture a, clear accumulators, go to SCAN. If sw=1, also load xor0/o at the same edge.
  - SCAN: each edge adds the indices and count of zero bits in a[idx+K-1:idx] to the accumulators, then idx += K. After the edge processing idx=W-K, go to DONE.
  - DONE: out_valid=1. Hold until an edge with out_ready=1, then go to IDLE.
- Latency: out_valid rises W/K edges after the accepting edge (8 for defaults). Throughput is one transaction per W/K+2 cycles.
- in_ready=0 in SCAN and DONE; in_valid is ignored there.
- DONE with out_ready=1 and in_valid=1 in the same cycle: return to IDLE only. The new operand is accepted on a following cycle.
- xor0 update, only when sw=1 at capture:
  - en=1: xor0 = a ^ (b >> SHIFT), zero-filled.
  - en=0: xor0[W-1:W/2] = a[W-1:W/2] ^ a[W/2-1:0]; xor0[W/2-1:0] = b[W-1:W/2] ^ b[W/2-1:0].
- o update, only when sw=1 at capture: o = ~(a[0] | b[0]).
- When sw=0 at capture, xor0 and o keep their previous values. sum and zcnt are always recomputed.
- Output stability: sum/zcnt are updated only on SCAN->DONE and stay stable from DONE until the next SCAN->DONE. xor0/o stay stable except at a capturing edge.
- Arithmetic: accumulators are sized SUM_W/ZC_W; overflow is impossible by construction.
- Reset during SCAN or DONE: transaction abandoned, no out_valid, outputs 0.
- a and b are don't-care outside the accepting edge.

Decomposition:
- Package supl_pkg holds:
  - state enum {IDLE, SCAN, DONE};
  - constant functions sum_w(W) and zc_w(W);
  - the en mode encoding (EN_SHIFT=1, EN_HALF=0).
- One sub-module, zero_slice_acc: a combinational K-bit slice that, given the slice and its base index, returns the index sum and zero count for that slice. It is instantiated once and driven from the scan counter.

Test Plan:
1. Reset then idle, W=32, K=4 -> all outputs 0; in_ready=1 on the first cycle after rst deasserts.
2. a=32'h1234_5678, b=32'hF000_0000, en=1, sw=1 -> xor0=32'h1D34_5678, o=1 right after acceptance; out_valid exactly 8 edges later.
3. a=32'hFFFF_0000, b=32'h1234_1234, en=0, sw=1 -> xor0=32'hFFFF_0000, o=1, sum=120, zcnt=16.
4. a=32'h0000_0000 then a=32'hFFFF_FFFE then a=32'h7FFF_FFFF, each with sw=0 -> sum/zcnt = 496/32, 0/1, 31/1; xor0/o unchanged from the previous transaction.
5. Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 -> outputs stable, in_ready=0, no second capture; the second operand is accepted only after out_ready is seen.
6. rst pulsed at scan cycle 3 -> no out_valid, all outputs 0; the next transaction completes correctly with full latency.
